// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bus for the boot-time program loader.
// master = stream source / memory side, slave = loader.
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory while holding the core in reset. `define LOADER_CHECKSUM_EN adds an XOR trailer check.
module instr_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_start_i,
  instr_loader_if.slave bus,
  output logic          cpu_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  accept;
  logic [15:0]           hdr_n;

  // in_ready is registered and tracks state_q, so a byte is taken exactly when both agree.
  assign accept = bus.in_valid && in_ready_q;
  assign hdr_n  = {bus.in_data, n_q[7:0]};

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (load_start_i) begin
          state_d    = S_HDR_LO;
          error_d    = 1'b0;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = bus.in_data;
          state_d  = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d = hdr_n;
          if (int'(hdr_n) > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = bus.in_data;
            2'd1: asm_d[15:8]  = bus.in_data;
            2'd2: asm_d[23:16] = bus.in_data;
            default: begin
              // Fourth byte bypasses the assembly register straight into the write word.
              state_d     = S_WRITE;
              mem_we_d    = 1'b1;
              mem_addr_d  = BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00});
              mem_wdata_d = DATA_WIDTH'({bus.in_data, asm_q});
            end
          endcase
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (idx_q + 16'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
`ifdef LOADER_CHECKSUM_EN
    in_ready_d = state_d inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CHK};
`else
    in_ready_d = state_d inside {S_HDR_LO, S_HDR_HI, S_DATA};
`endif
    busy_d    = (state_d != S_IDLE) && (state_d != S_ERR);
    cpu_rst_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= '0;
    else         csum_q <= csum_d;
  end
`endif

  // Partial-word lanes are pure data; byte_cnt decides which lanes are meaningful.
  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst_o     = cpu_rst_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: memory writes are checked against a scoreboard queue,
// control outputs against hand-derived values; checksum scenarios apply when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic load_start;
  logic cpu_rst, busy, done, error;

  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  logic [7:0] prog [10];

  instr_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_start_i (load_start),
    .bus          (bus),
    .cpu_rst_o    (cpu_rst),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", bus.mem_we, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", bus.mem_addr, e.addr);
        check("we_data", bus.mem_wdata, e.data);
        check("in_ready_in_write", bus.in_ready, 32'd0);
      end
    end
    if (done === 1'b1) begin
      check("cpu_rst_at_done", cpu_rst, 32'd0);
      check("busy_at_done", busy, 32'd0);
    end
  end

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("handshake_timeout", bus.in_ready, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_done_seen"}, done, 32'd1);
    check({tag, "_done_latency"}, c, exp_lat);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 32'd0);
    check({tag, "_cpu_rst_after"}, cpu_rst, 32'd0);
    check({tag, "_error_after"}, error, 32'd0);
  endtask

  // Standard two-word program; gap_max > 0 inserts random idle cycles between bytes.
  task automatic load_prog(input string tag, input int gap_max);
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back('{32'h0, 32'h00500093});
    exp_q.push_back('{32'h4, 32'h00A00113});
    pulse_start();
    check({tag, "_cpu_rst_start"}, cpu_rst, 32'd1);
    check({tag, "_busy_start"}, busy, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) cs = cs ^ prog[i];
      send_byte(prog[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, 0);
    wait_done(tag, 0);
`else
    wait_done(tag, 1);
`endif
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    prog = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    rst_n        = 1'b0;
    load_start   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 32'd0);
    check("rst_mem_we", bus.mem_we, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_rst", cpu_rst, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_error", error, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal load.
    load_prog("normal", 0);

    // Zero-length load: done in the cycle right after the second header byte (no checksum).
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check("zero_done_now", done, 32'd1);
    wait_done("zero", 0);

    // Random gaps; in_valid stays high across WRITE when the gap is 0.
    load_prog("gaps", 3);
    load_prog("gaps2", 1);

    // Oversize header N=1025.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("over_error", error, 32'd1);
    check("over_cpu_rst", cpu_rst, 32'd1);
    check("over_busy", busy, 32'd0);
    check("over_in_ready", bus.in_ready, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("over_error_sticky", error, 32'd1);
    check("over_cpu_rst_held", cpu_rst, 32'd1);
    pulse_start();
    check("over_error_cleared", error, 32'd0);
    check("over_busy_restart", busy, 32'd1);
    // The restarted load continues from HDR_LO.
    exp_q.push_back('{32'h0, 32'h00500093});
    exp_q.push_back('{32'h4, 32'h00A00113});
    begin
      logic [7:0] cs;
      cs = 8'h00;
      for (int i = 0; i < 10; i++) begin
        if (i >= 2) cs = cs ^ prog[i];
        send_byte(prog[i], 0);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs, 0);
      wait_done("after_err", 0);
`else
      wait_done("after_err", 1);
`endif
    end
    check("after_err_writes_left", exp_q.size(), 32'd0);

    // Reset in the middle of word 0.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(prog[i], 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 32'd0);
    check("midrst_cpu_rst", cpu_rst, 32'd0);
    check("midrst_busy", busy, 32'd0);
    check("midrst_error", error, 32'd0);
    check("midrst_mem_we", bus.mem_we, 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'd0);
    check("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_prog("post_rst", 0);

`ifdef LOADER_CHECKSUM_EN
    // N=1, good trailer 0xC3.
    exp_q.push_back('{32'h0, 32'h00500093});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'hC3, 0);
    wait_done("csum_ok", 0);
    check("csum_ok_writes_left", exp_q.size(), 32'd0);
    // Bad trailer.
    exp_q.push_back('{32'h0, 32'h00500093});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("csum_bad_error", error, 32'd1);
    check("csum_bad_cpu_rst", cpu_rst, 32'd1);
    check("csum_bad_busy", busy, 32'd0);
    check("csum_bad_done", done, 32'd0);
    check("csum_bad_written", exp_q.size(), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_writes_left", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
